// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VESA raster timing generator (sync, active qualifiers,
// pixel coordinates, constant resolution words) in the pxl_clk domain.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic        pxl_clk,
  input  logic        pxl_rst_n,
  input  logic        timing_en,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic [31:0] horz_res,
  output logic [31:0] vert_res,
  output logic        hsync,
  output logic        vsync,
  output logic        horz_active,
  output logic        vert_active,
  output logic        frame_active,
  output logic [11:0] pxl_x,
  output logic [11:0] pxl_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  // 13-bit bounds so a sync region ending exactly at 4096 still compares correctly
  localparam logic [12:0] H_ACT_E  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_E  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON    = 1'(HSYNC_POL);
  localparam logic        VS_ON    = 1'(VSYNC_POL);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [12:0] h_ext;
  logic [12:0] v_ext;
  logic        h_act_d;
  logic        v_act_d;
  logic        h_sync_d;
  logic        v_sync_d;
  logic        origin_d;

  // Resolution words are constants, valid even while in reset
  assign horz_res = 32'(H_ACTIVE);
  assign vert_res = 32'(V_ACTIVE);

  // Raster position counters; disable parks the raster at the origin
  always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
    if (!pxl_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!timing_en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Combinational decode of the current counter position
  always_comb begin
    h_ext    = {1'b0, h_cnt};
    v_ext    = {1'b0, v_cnt};
    h_act_d  = h_ext < H_ACT_E;
    v_act_d  = v_ext < V_ACT_E;
    h_sync_d = (h_ext >= HS_START) && (h_ext < HS_END);
    v_sync_d = (v_ext >= VS_START) && (v_ext < VS_END);
    origin_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Output register stage: every output describes the same raster position
  always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
    if (!pxl_rst_n) begin
      hsync        <= ~HS_ON;
      vsync        <= ~VS_ON;
      horz_active  <= 1'b0;
      vert_active  <= 1'b0;
      frame_active <= 1'b0;
      frame_start  <= 1'b0;
      pxl_x        <= '0;
      pxl_y        <= '0;
    end else if (!timing_en) begin
      hsync        <= ~HS_ON;
      vsync        <= ~VS_ON;
      horz_active  <= 1'b0;
      vert_active  <= 1'b0;
      frame_active <= 1'b0;
      frame_start  <= 1'b0;
      pxl_x        <= '0;
      pxl_y        <= '0;
    end else begin
      hsync        <= h_sync_d ? HS_ON : ~HS_ON;
      vsync        <= v_sync_d ? VS_ON : ~VS_ON;
      horz_active  <= h_act_d;
      vert_active  <= v_act_d;
      frame_active <= h_act_d & v_act_d;
      frame_start  <= origin_d;
      pxl_x        <= h_cnt;
      pxl_y        <= v_cnt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic first_seen;

  // Frame counter: skips the first frame_start after reset or re-enable
  always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
    if (!pxl_rst_n) begin
      frame_cnt  <= '0;
      first_seen <= 1'b0;
    end else if (!timing_en) begin
      frame_cnt  <= '0;
      first_seen <= 1'b0;
    end else if (origin_d) begin
      if (first_seen) frame_cnt <= frame_cnt + 16'd1;
      first_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen.
// A reduced raster (32x20 totals, vsync active-high) exercises frame-level
// behaviour; a default-parameter instance checks the 640x480 line timing.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst_n;
  logic        en;

  logic [31:0] s_hres, s_vres, d_hres, d_vres;
  logic        s_hs, s_vs, s_ha, s_va, s_fa, s_fs;
  logic        d_hs, d_vs, d_ha, d_va, d_fa, d_fs;
  logic [11:0] s_x, s_y, d_x, d_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] s_fc, d_fc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .HSYNC_POL(0), .VSYNC_POL(1)
  ) dut (
    .pxl_clk(clk), .pxl_rst_n(rst_n), .timing_en(en),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(s_fc),
`endif
    .horz_res(s_hres), .vert_res(s_vres), .hsync(s_hs), .vsync(s_vs),
    .horz_active(s_ha), .vert_active(s_va), .frame_active(s_fa),
    .pxl_x(s_x), .pxl_y(s_y), .frame_start(s_fs)
  );

  vga_timing_gen dut_def (
    .pxl_clk(clk), .pxl_rst_n(rst_n), .timing_en(en),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(d_fc),
`endif
    .horz_res(d_hres), .vert_res(d_vres), .hsync(d_hs), .vsync(d_vs),
    .horz_active(d_ha), .vert_active(d_va), .frame_active(d_fa),
    .pxl_x(d_x), .pxl_y(d_y), .frame_start(d_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int fs_cnt, fs_pos1, fa_cnt, vs_cnt, vs_first, vs_first_x, vs_first_y;
  int hs_low_l0, hs_first_x, trk_err;
  int d_ha_cnt, d_ha_drop, d_hs_cnt, d_hs_first_x, d_x800, d_y800;
  int ex, ey;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    #23;
    // reset state, sampled mid-cycle
    chk("rst_s_hsync", s_hs, 1);
    chk("rst_s_vsync", s_vs, 0);
    chk("rst_s_actives", {s_ha, s_va, s_fa}, 0);
    chk("rst_s_fstart", s_fs, 0);
    chk("rst_s_xy", {s_x, s_y}, 0);
    chk("rst_s_hres", s_hres, 16);
    chk("rst_s_vres", s_vres, 12);
    chk("rst_d_syncs", {d_hs, d_vs}, 2'b11);
    chk("rst_d_actives", {d_ha, d_va, d_fa, d_fs}, 0);
    chk("rst_d_hres", d_hres, 640);
    chk("rst_d_vres", d_vres, 480);

    rst_n = 1'b1;
    step();
    chk("first_fstart", s_fs, 1);
    chk("first_factive", s_fa, 1);
    chk("first_xy", {s_x, s_y}, 0);
    chk("first_d_fstart", {d_fs, d_fa}, 2'b11);

    // two reduced frames (1280 samples) plus one full default line
    fs_cnt = 0; fs_pos1 = -1; fa_cnt = 0; vs_cnt = 0; vs_first = -1;
    vs_first_x = -1; vs_first_y = -1; hs_low_l0 = 0; hs_first_x = -1; trk_err = 0;
    d_ha_cnt = 0; d_ha_drop = -1; d_hs_cnt = 0; d_hs_first_x = -1; d_x800 = -1; d_y800 = -1;
    for (int i = 0; i < 1280; i++) begin
      ex = i % 32;
      ey = (i / 32) % 20;
      if (s_fs) begin
        fs_cnt++;
        if (i != 0 && fs_pos1 < 0) fs_pos1 = i;
      end
      if (s_fa) fa_cnt++;
      if (s_vs) begin
        vs_cnt++;
        if (vs_first < 0) begin
          vs_first = i; vs_first_x = int'(s_x); vs_first_y = int'(s_y);
        end
      end
      if (i < 32 && !s_hs) begin
        hs_low_l0++;
        if (hs_first_x < 0) hs_first_x = int'(s_x);
      end
      if (int'(s_x) != ex || int'(s_y) != ey || s_ha !== (ex < 16) ||
          s_va !== (ey < 12) || s_fa !== (s_ha & s_va) || s_fs !== (ex == 0 && ey == 0))
        trk_err++;
      if (i < 800) begin
        if (d_ha) d_ha_cnt++;
        else if (d_ha_drop < 0) d_ha_drop = i;
        if (!d_hs) begin
          d_hs_cnt++;
          if (d_hs_first_x < 0) d_hs_first_x = int'(d_x);
        end
      end
      if (i == 800) begin
        d_x800 = int'(d_x); d_y800 = int'(d_y);
      end
      step();
    end
    chk("frame_start_count", fs_cnt, 2);
    chk("frame_period", fs_pos1, 640);
    chk("frame_active_clocks", fa_cnt, 384);
    chk("vsync_clocks", vs_cnt, 192);
    chk("vsync_start_clock", vs_first, 448);
    chk("vsync_start_xy", {vs_first_x[11:0], vs_first_y[11:0]}, {12'd0, 12'd14});
    chk("hsync_width", hs_low_l0, 6);
    chk("hsync_start_x", hs_first_x, 20);
    chk("tracking_errors", trk_err, 0);
    chk("def_hactive_clocks", d_ha_cnt, 640);
    chk("def_hactive_drop", d_ha_drop, 640);
    chk("def_hsync_width", d_hs_cnt, 96);
    chk("def_hsync_start_x", d_hs_first_x, 656);
    chk("def_line_period", {d_x800[11:0], d_y800[11:0]}, {12'd0, 12'd1});

    // timing_en drop mid-frame at (10,5)
    repeat (170) step();
    chk("pre_drop_xy", {s_x, s_y}, {12'd10, 12'd5});
    en = 1'b0;
    step();
    chk("drop_idle", {s_hs, s_vs, s_ha, s_va, s_fa, s_fs}, 6'b100000);
    chk("drop_xy", {s_x, s_y}, 0);
    repeat (4) step();
    chk("drop_hold", {s_hs, s_va, s_fs, s_x}, {1'b1, 1'b0, 1'b0, 12'd0});
    en = 1'b1;
    step();
    chk("reen_fstart", {s_fs, s_fa}, 2'b11);
    chk("reen_xy", {s_x, s_y}, 0);
    step();
    chk("reen_next", {s_fs, s_x, s_y}, {1'b0, 12'd1, 12'd0});

    // asynchronous reset inside the hsync region
    repeat (21) step();
    chk("pre_rst_state", {s_hs, s_va, s_x}, {1'b0, 1'b1, 12'd22});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_syncs", {s_hs, s_vs}, 2'b10);
    chk("async_rst_actives", {s_ha, s_va, s_fa, s_fs}, 0);
    chk("async_rst_xy", {s_x, s_y}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("restart_fstart", {s_fs, s_fa}, 2'b11);
    chk("restart_xy", {s_x, s_y}, 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("fcnt_frame0", s_fc, 0);
    repeat (640) step();
    chk("fcnt_frame1", {s_fs, s_fc}, {1'b1, 16'd1});
    repeat (640) step();
    chk("fcnt_frame2", {s_fs, s_fc}, {1'b1, 16'd2});
    en = 1'b0;
    step();
    chk("fcnt_cleared", s_fc, 0);
    en = 1'b1;
    step();
    chk("fcnt_reen", {s_fs, s_fc}, {1'b1, 16'd0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
